// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//
// Purpose : Shared types and constants for the ALU response checker.
//           - operation_t    : ALU opcode encoding
//           - ERR_*_PAT      : expected error patterns. Each 3-bit
//                              {data, crc, op} code appears twice in the
//                              6-bit response error field.
//           - exp_rec_t      : the width-independent part of an expected
//                              record. The expected result C travels next to
//                              it because its width is a module parameter.
//           - chk_state_t    : checker FSM states
//           - is_legal_op / err_pattern : helper functions
//
// Ports   : none (package)
//
// Config  : ALU_CHECKER_FAIL_CAPTURE_EN adds the opcode to exp_rec_t so that
//           the capture logic can report it.
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  localparam logic [5:0] ERR_NONE     = 6'b000000;
  localparam logic [5:0] ERR_DATA_PAT = 6'b100100;
  localparam logic [5:0] ERR_CRC_PAT  = 6'b010010;
  localparam logic [5:0] ERR_OP_PAT   = 6'b001001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ERROR  = 2'b10
  } chk_state_t;

  typedef struct packed {
    logic [3:0] flags;
    logic [5:0] err;
`ifdef ALU_CHECKER_FAIL_CAPTURE_EN
    operation_t op;
`endif
  } exp_rec_t;

  // Only the four encoded operations are valid. Every other opcode is
  // reported as an opcode error.
  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // Error precedence: a framing error hides a CRC error, and a CRC error
  // hides a bad opcode.
  function automatic logic [5:0] err_pattern(input logic       data_err,
                                             input logic       crc_err,
                                             input logic [2:0] op);
    if (data_err)            return ERR_DATA_PAT;
    else if (crc_err)        return ERR_CRC_PAT;
    else if (!is_legal_op(op)) return ERR_OP_PAT;
    else                     return ERR_NONE;
  endfunction

endpackage

// File: rtl/alu_checker_fifo.sv
// ----------------------------------------------------------------------------
// alu_checker_fifo
//
// Purpose : Circular-buffer FIFO that holds expected records between request
//           acceptance and response arrival. The head entry is presented
//           combinationally, so a pop compares against it in the same cycle.
//           A push and a pop in the same cycle are allowed even when the FIFO
//           is full. The slot being read is the one that gets overwritten.
//
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset (empties the FIFO)
//           clr    - synchronous flush; takes priority over push/pop
//           push   - write wdata at the tail
//           pop    - drop the head entry
//           wdata  - record to store (WIDTH bits)
//           rdata  - current head record (WIDTH bits)
//           count  - occupancy, 0..DEPTH
//
// Params  : WIDTH - record width; DEPTH - entries (power of two)
// ----------------------------------------------------------------------------
module alu_checker_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage has no reset. Occupancy and pointers decide which entries are
  // valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The occupancy
  // counter removes any ambiguity between the full and empty cases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/alu_checker.sv
// ----------------------------------------------------------------------------
// alu_checker
//
// Purpose : Scoreboard-style checker placed around an ALU. For each accepted
//           request it computes the expected result, flags and error code and
//           queues them. Each response is compared with the oldest queued
//           expectation. The result is reported one cycle later and is
//           accumulated in saturating pass/fail counters. A response that
//           arrives with nothing outstanding is a protocol violation. It
//           parks the checker in ERROR until clr or reset.
//
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           clr                 - synchronous clear of counters, queue, error
//           req_valid/req_ready - request handshake
//           req_a, req_b        - operands (DATA_W)
//           req_op              - opcode (operation_t)
//           req_data_err        - upstream framing error
//           req_crc_err         - upstream CRC error
//           rsp_valid           - response strobe (no backpressure)
//           rsp_c               - received result (DATA_W)
//           rsp_flags           - received {carry, overflow, zero, negative}
//           rsp_err             - received error code (6 bits)
//           chk_valid, chk_pass - one-cycle compare result
//           pass_cnt, fail_cnt  - saturating counters (CNT_W)
//           outstanding         - queue occupancy
//           proto_err           - high while in ERROR
//           cap_*               - first failing compare (capture build only)
//
// Config  : define ALU_CHECKER_FAIL_CAPTURE_EN to add the cap_* outputs.
//           They latch the first failing compare until clr or reset.
// ----------------------------------------------------------------------------
module alu_checker
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_W-1:0]      req_a,
  input  logic [DATA_W-1:0]      req_b,
  input  logic [2:0]             req_op,
  input  logic                   req_data_err,
  input  logic                   req_crc_err,
  input  logic                   rsp_valid,
  input  logic [DATA_W-1:0]      rsp_c,
  input  logic [3:0]             rsp_flags,
  input  logic [5:0]             rsp_err,
  output logic                   chk_valid,
  output logic                   chk_pass,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   proto_err
`ifdef ALU_CHECKER_FAIL_CAPTURE_EN
  ,
  output logic                   cap_valid,
  output logic [DATA_W-1:0]      cap_exp_c,
  output logic [DATA_W-1:0]      cap_rsp_c,
  output logic [3:0]             cap_exp_flags,
  output logic [3:0]             cap_rsp_flags,
  output logic [2:0]             cap_op
`endif
);

  localparam int REC_W = DATA_W + $bits(exp_rec_t);
  localparam int MSB   = DATA_W - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t        state;
  chk_state_t        state_next;

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] exp_c;
  logic              exp_carry;
  logic              exp_ovf;
  exp_rec_t          exp_rec;

  logic [REC_W-1:0]  push_data;
  logic [REC_W-1:0]  head_data;
  logic [DATA_W-1:0] head_c;
  exp_rec_t          head_rec;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              cmp_pass;

  // Both arithmetic results are widened by one bit. The top bit is then the
  // unsigned carry for ADD and the borrow for SUB.
  assign sum_ext  = {1'b0, req_b} + {1'b0, req_a};
  assign diff_ext = {1'b0, req_b} - {1'b0, req_a};

  // Build the expected record from the request. Any upstream error makes the
  // ALU output meaningless, so C and the flags are zeroed in that case. Only
  // the error code is checked for such transactions.
  always_comb begin
    exp_c     = '0;
    exp_carry = 1'b0;
    exp_ovf   = 1'b0;
    exp_rec   = '0;
    exp_rec.err = err_pattern(req_data_err, req_crc_err, req_op);
    case (operation_t'(req_op))
      OP_AND: exp_c = req_b & req_a;
      OP_OR:  exp_c = req_b | req_a;
      OP_ADD: begin
        {exp_carry, exp_c} = sum_ext;
        exp_ovf = (req_a[MSB] == req_b[MSB]) && (sum_ext[MSB] != req_a[MSB]);
      end
      OP_SUB: begin
        {exp_carry, exp_c} = diff_ext;
        exp_ovf = (req_a[MSB] != req_b[MSB]) && (diff_ext[MSB] != req_b[MSB]);
      end
      default: exp_c = '0;
    endcase
    if (exp_rec.err != ERR_NONE) begin
      exp_c         = '0;
      exp_rec.flags = '0;
    end else begin
      exp_rec.flags = {exp_carry, exp_ovf, (exp_c == '0), exp_c[MSB]};
    end
`ifdef ALU_CHECKER_FAIL_CAPTURE_EN
    exp_rec.op = operation_t'(req_op);
`endif
  end

  assign push_data           = {exp_c, exp_rec};
  assign {head_c, head_rec}  = head_data;

  alu_checker_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head_data),
    .count (outstanding)
  );

  assign fifo_empty = (outstanding == '0);
  assign fifo_full  = (outstanding == ($clog2(DEPTH)+1)'(DEPTH));

  // Handshake and next-state logic. In ERROR both directions are ignored. A
  // same-cycle pop frees a slot, so a full queue can still accept a request.
  // clr overrides everything and returns to IDLE.
  always_comb begin
    req_ready  = 1'b0;
    pop        = 1'b0;
    state_next = state;
    if (state != ST_ERROR) begin
      pop       = rsp_valid && !fifo_empty;
      req_ready = !fifo_full || pop;
    end
    push = req_valid && req_ready && !clr;

    if (clr) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rsp_valid && fifo_empty) begin
            state_next = ST_ERROR;
          end else if (push && !pop) begin
            state_next = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (rsp_valid && fifo_empty) begin
            state_next = ST_ERROR;
          end else if (pop && !push && (outstanding == ($clog2(DEPTH)+1)'(1))) begin
            state_next = ST_IDLE;
          end
        end
        ST_ERROR: state_next = ST_ERROR;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // When an error was expected, only the error code has to match. Otherwise
  // the result and flags must match and the response must carry no error.
  always_comb begin
    cmp_pass = 1'b0;
    if (head_rec.err != ERR_NONE) begin
      cmp_pass = (rsp_err == head_rec.err);
    end else begin
      cmp_pass = (rsp_c == head_c) && (rsp_flags == head_rec.flags) &&
                 (rsp_err == ERR_NONE);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign proto_err = (state == ST_ERROR);

  // Compare result and counters are registered together, so the counters
  // already include a compare in the cycle its chk_valid pulse is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else if (clr) begin
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      chk_valid <= pop;
      chk_pass  <= pop && cmp_pass;
      if (pop) begin
        if (cmp_pass) begin
          if (pass_cnt != CNT_MAX) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end
        end else if (fail_cnt != CNT_MAX) begin
          fail_cnt <= fail_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ALU_CHECKER_FAIL_CAPTURE_EN
  // Keep the first failing compare for post-mortem debug. Later failures are
  // ignored until clr or reset re-arms the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid     <= 1'b0;
      cap_exp_c     <= '0;
      cap_rsp_c     <= '0;
      cap_exp_flags <= '0;
      cap_rsp_flags <= '0;
      cap_op        <= '0;
    end else if (clr) begin
      cap_valid     <= 1'b0;
      cap_exp_c     <= '0;
      cap_rsp_c     <= '0;
      cap_exp_flags <= '0;
      cap_rsp_flags <= '0;
      cap_op        <= '0;
    end else if (pop && !cmp_pass && !cap_valid) begin
      cap_valid     <= 1'b1;
      cap_exp_c     <= head_c;
      cap_rsp_c     <= rsp_c;
      cap_exp_flags <= head_rec.flags;
      cap_rsp_flags <= rsp_flags;
      cap_op        <= head_rec.op;
    end
  end
`endif

endmodule
